instruction_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/writeback controller that drives the ALU. Fetches 16-bit instruction words

---
 rtl/instruction_sequencer.sv | 171 +++++++++++++++++
 tb/tb_instruction_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches 16-bit words from a synchronous program ROM,
// decodes them for the ALU and register file, and commits results.
// The PC, the instruction register and the architectural flags all live here.

package instruction_sequencer_pkg;
    // Architectural ALU flags, carried between instructions
    typedef struct packed {
        logic Carry;
        logic Zero;
        logic Negative;
        logic Overflow;
    } sFlags;
endpackage

module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int         AddrWidth     = 8,
    parameter int         DataWidth     = 16,
    parameter logic [5:0] JumpOpcode    = 6'h3D,
    parameter logic [5:0] BranchZOpcode = 6'h3E,
    parameter logic [5:0] HaltOpcode    = 6'h3F
) (
    input  logic                 Clock_i,
    input  logic                 Reset_i,
    input  logic                 Run_i,
    output logic [AddrWidth-1:0] PmemAddr_o,
    output logic                 PmemRdEn_o,
    input  logic [15:0]          PmemRData_i,
    output logic [3:0]           RfSrcIdx_o,
    output logic [3:0]           RfDestIdx_o,
    output logic                 RfWrEn_o,
    output logic [DataWidth-1:0] RfWrData_o,
    output logic [5:0]           AluOperation_o,
    output logic [5:0]           AluImm_o,
    output sFlags                AluInFlags_o,
    input  logic [DataWidth-1:0] AluOutDest_i,
    input  sFlags                AluOutFlags_i,
    output logic                 Busy_o,
    output logic                 Halted_o,
    output logic [2:0]           DbgState_o
);

    // The relative-jump sign extension below needs room above the immediate.
    localparam int ImmediateWidth = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    sFlags                 flags_q, flags_d;
    sFlags                 res_flags_q, res_flags_d;
    logic [DataWidth-1:0]  res_q, res_d;

    logic [5:0]            opcode;
    logic                  is_jump, is_branch, is_halt;
    logic [AddrWidth-1:0]  pc_inc, pc_rel;

    assign opcode    = ir_q[15:10];
    assign is_jump   = (opcode == JumpOpcode);
    assign is_branch = (opcode == BranchZOpcode);
    assign is_halt   = (opcode == HaltOpcode);

    // PC arithmetic is modulo 2**AddrWidth; the immediate is a signed offset
    // relative to the address of the following instruction.
    assign pc_inc = pc_q + AddrWidth'(1);
    assign pc_rel = pc_inc + {{(AddrWidth-ImmediateWidth){ir_q[5]}}, ir_q[5:0]};

    // Decoded fields are presented straight from the instruction register;
    // Src and Imm deliberately overlap in IR[5:0].
    assign PmemAddr_o     = pc_q;
    assign RfSrcIdx_o     = ir_q[5:2];
    assign RfDestIdx_o    = ir_q[9:6];
    assign AluOperation_o = opcode;
    assign AluImm_o       = ir_q[5:0];
    assign AluInFlags_o   = flags_q;
    assign RfWrData_o     = res_q;
    assign Busy_o         = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                            (state_q == S_EXEC)  || (state_q == S_WB);
    assign Halted_o       = (state_q == S_HALTED);
    assign DbgState_o     = state_q;

    // Next-state and strobe decode. ROM protocol: PmemRdEn_o is a one-cycle
    // request with PmemAddr_o; the ROM answers on PmemRData_i in the next cycle
    // unconditionally (no stall), which is when WAIT captures it into IR.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        flags_d     = flags_q;
        res_d       = res_q;
        res_flags_d = res_flags_q;
        PmemRdEn_o  = 1'b0;
        RfWrEn_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Run_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                PmemRdEn_o = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                ir_d    = PmemRData_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_halt) begin
                    state_d = S_HALTED;
                end else begin
                    // Control-flow opcodes do not use the ALU result.
                    if (!is_jump && !is_branch) begin
                        res_d       = AluOutDest_i;
                        res_flags_d = AluOutFlags_i;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d = pc_inc;
                if (is_jump) begin
                    pc_d = pc_rel;
                end else if (is_branch) begin
                    if (flags_q.Zero) begin
                        pc_d = pc_rel;
                    end
                end else begin
                    RfWrEn_o = 1'b1;
                    flags_d  = res_flags_q;
                end
                state_d = Run_i ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight instruction.
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            flags_q     <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            flags_q     <= flags_d;
            res_q       <= res_d;
            res_flags_q <= res_flags_d;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: ROM and register-file/ALU environment,
// an instruction-level reference model, directed scenarios and random programs.

module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    localparam int         AW      = 8;
    localparam int         DW      = 16;
    localparam logic [5:0] OP_MOVE = 6'h00;
    localparam logic [5:0] OP_ADC  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_JMP  = 6'h3D;
    localparam logic [5:0] OP_BRZ  = 6'h3E;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic run;
    always #5 clk = ~clk;

    logic [AW-1:0] pmem_addr;
    logic          pmem_rd_en;
    logic [15:0]   pmem_rdata;
    logic [3:0]    rf_src, rf_dest;
    logic          rf_wr_en;
    logic [DW-1:0] rf_wr_data;
    logic [5:0]    alu_op, alu_imm;
    sFlags         alu_in_flags, alu_out_flags;
    logic [DW-1:0] alu_out_dest;
    logic          busy, halted;
    logic [2:0]    dbg_state;

    instruction_sequencer dut (
        .Clock_i        (clk),
        .Reset_i        (rst),
        .Run_i          (run),
        .PmemAddr_o     (pmem_addr),
        .PmemRdEn_o     (pmem_rd_en),
        .PmemRData_i    (pmem_rdata),
        .RfSrcIdx_o     (rf_src),
        .RfDestIdx_o    (rf_dest),
        .RfWrEn_o       (rf_wr_en),
        .RfWrData_o     (rf_wr_data),
        .AluOperation_o (alu_op),
        .AluImm_o       (alu_imm),
        .AluInFlags_o   (alu_in_flags),
        .AluOutDest_i   (alu_out_dest),
        .AluOutFlags_i  (alu_out_flags),
        .Busy_o         (busy),
        .Halted_o       (halted),
        .DbgState_o     (dbg_state)
    );

    // ---------------- environment ----------------
    logic [15:0]   rom       [256];
    logic [DW-1:0] regs      [16];
    logic [DW-1:0] init_regs [16];
    logic          load_regs;

    always @(posedge clk) begin
        if (pmem_rd_en) pmem_rdata <= rom[pmem_addr];
    end

    always @(posedge clk) begin
        if (load_regs) regs <= init_regs;
        else if (rf_wr_en) regs[rf_dest] <= rf_wr_data;
    end

    // ALU behaviour: MOVE (default) = Src, ADC = Dest+Src+C, SUB = Dest-Src.
    // Returns {result, Carry, Zero, Negative, Overflow}.
    function automatic logic [DW+3:0] alu_model(input logic [5:0] op, input logic [DW-1:0] d,
                                                 input logic [DW-1:0] s, input logic cin);
        logic [DW:0]   sum;
        logic [DW-1:0] r;
        logic          v;
        v = 1'b0;
        case (op)
            OP_ADC: begin
                sum = {1'b0, d} + {1'b0, s} + {{DW{1'b0}}, cin};
                v   = (d[DW-1] == s[DW-1]) && (sum[DW-1] != d[DW-1]);
            end
            OP_SUB: begin
                sum = {1'b0, d} - {1'b0, s};
                v   = (d[DW-1] != s[DW-1]) && (sum[DW-1] != d[DW-1]);
            end
            default: sum = {1'b0, s};
        endcase
        r = sum[DW-1:0];
        return {r, sum[DW], (r == '0), r[DW-1], v};
    endfunction

    always_comb begin
        {alu_out_dest, alu_out_flags} = alu_model(alu_op, regs[rf_dest], regs[rf_src], alu_in_flags.Carry);
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [3:0]    exp_dest_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Instruction-level reference state
    logic [AW-1:0] m_pc;
    sFlags         m_flags;
    logic [DW-1:0] m_regs [16];
    logic          m_halt;
    int            cyc, last_cyc;
    logic          have_last, run_low;

    // Executes one whole instruction on the model when the DUT fetches it.
    task automatic model_step();
        logic [15:0]   instr;
        logic [5:0]    op;
        logic [3:0]    d, s;
        logic [AW-1:0] target;
        logic [DW+3:0] r;
        instr  = rom[m_pc];
        op     = instr[15:10];
        d      = instr[9:6];
        s      = instr[5:2];
        target = m_pc + 8'd1 + {{2{instr[5]}}, instr[5:0]};
        if (op == OP_HALT) begin
            m_halt = 1'b1;
        end else if (op == OP_JMP) begin
            m_pc = target;
        end else if (op == OP_BRZ) begin
            m_pc = m_flags.Zero ? target : m_pc + 8'd1;
        end else begin
            r = alu_model(op, m_regs[d], m_regs[s], m_flags.Carry);
            m_regs[d] = r[DW+3:4];
            m_flags   = r[3:0];
            exp_q.push_back(r[DW+3:4]);
            exp_dest_q.push_back(d);
            m_pc = m_pc + 8'd1;
        end
    endtask

    // Per-cycle monitor, called on every falling edge.
    task automatic mon();
        cyc++;
        if (rst) begin
            m_pc = '0; m_flags = '0; m_halt = 1'b0;
            exp_q.delete(); exp_dest_q.delete();
            have_last = 1'b0; run_low = 1'b0;
            for (int i = 0; i < 16; i++) m_regs[i] = init_regs[i];
            return;
        end
        if (!run) run_low = 1'b1;
        if (pmem_rd_en) begin
            check("fetch_after_halt", 32'(m_halt), 32'd0);
            check("fetch_addr", 32'(pmem_addr), 32'(m_pc));
            if (have_last && !run_low) check("fetch_spacing", 32'(cyc - last_cyc), 32'd4);
            have_last = 1'b1; last_cyc = cyc; run_low = 1'b0;
            model_step();
        end
        if (rf_wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                check("wr_dest", 32'(rf_dest), 32'(exp_dest_q.pop_front()));
                check("wr_data", 32'(rf_wr_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        mon();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 16; i++) init_regs[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; load_regs = 1'b1;
        repeat (2) step();
        load_regs = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("rst_addr", 32'(pmem_addr), 32'd0);
        check("rst_rden", 32'(pmem_rd_en), 32'd0);
        check("rst_wren", 32'(rf_wr_en), 32'd0);
        check("rst_wdata", 32'(rf_wr_data), 32'd0);
        check("rst_flags", 32'(alu_in_flags), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
    endtask

    task automatic wait_fetch(input string tag, input logic [AW-1:0] exp_addr);
        int n;
        n = 0;
        step();
        while (!pmem_rd_en && n < 10) begin
            step();
            n++;
        end
        check({tag, "_seen"}, 32'(pmem_rd_en), 32'd1);
        check(tag, 32'(pmem_addr), 32'(exp_addr));
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (!halted && n < 12) begin
            step();
            n++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic count_idle(input string tag, input int cycles);
        int rd;
        rd = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (pmem_rd_en || rf_wr_en) rd++;
        end
        check(tag, 32'(rd), 32'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        run = 1'b0;
        n = 0;
        while (busy && n < 12) begin
            step();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_pc"}, 32'(pmem_addr), 32'(m_pc));
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] d, s;
        logic [5:0] imm;
        d   = 4'($urandom_range(0, 15));
        s   = 4'($urandom_range(0, 15));
        imm = 6'($urandom_range(0, 63));
        case ($urandom_range(0, 9))
            0, 1:    return {OP_MOVE, d, s, 2'b00};
            2, 3:    return {OP_ADC, d, s, 2'b00};
            4, 5:    return {OP_SUB, d, s, 2'b00};
            6:       return {OP_SUB, d, d, 2'b00};
            7, 8:    return {OP_BRZ, d, imm};
            default: return {OP_JMP, d, imm};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; run = 1'b0; load_regs = 1'b0;
        cyc = 0; last_cyc = 0; have_last = 1'b0; run_low = 1'b0;
        m_pc = '0; m_flags = '0; m_halt = 1'b0;

        // MOVE R1 <- R2 writes back on the fourth cycle
        clear_rom();
        rom[0] = {OP_MOVE, 4'd1, 4'd2, 2'b00};
        init_regs[2] = 16'h1234;
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t1_no_wr_early", 32'(rf_wr_en), 32'd0);
        end
        step();
        check("t1_wr_c4", 32'(rf_wr_en), 32'd1);
        check("t1_dest", 32'(rf_dest), 32'd1);
        check("t1_data", 32'(rf_wr_data), 32'h1234);
        step();
        check("t1_pc", 32'(pmem_addr), 32'd1);
        drain("t1");

        // ADC yielding zero, then a taken BranchZ back to address 0
        clear_rom();
        rom[0] = {OP_ADC, 4'd4, 4'd5, 2'b00};
        rom[1] = {OP_BRZ, 4'd0, 6'h3E};
        do_reset();
        run = 1'b1;
        wait_fetch("t2_f0", 8'h00);
        wait_fetch("t2_f1", 8'h01);
        wait_fetch("t2_f2", 8'h00);
        wait_fetch("t2_f3", 8'h01);
        wait_fetch("t2_f4", 8'h00);
        drain("t2");

        // BranchZ not taken: falls through, flags keep the ADC result
        clear_rom();
        rom[0] = {OP_ADC, 4'd6, 4'd7, 2'b00};
        rom[1] = {OP_BRZ, 4'd0, 6'h3E};
        rom[2] = {OP_HALT, 10'd0};
        init_regs[6] = 16'hFFFF;
        init_regs[7] = 16'h0002;
        do_reset();
        run = 1'b1;
        wait_fetch("t3_f0", 8'h00);
        wait_fetch("t3_f1", 8'h01);
        wait_fetch("t3_f2", 8'h02);
        wait_halt("t3");
        check("t3_flags", 32'(alu_in_flags), 32'b1000);
        check("t3_pc", 32'(pmem_addr), 32'd2);

        // Jump wrap-around through 8'hFF, then Halt ignores Run
        clear_rom();
        rom[0]     = {OP_JMP, 4'd0, 6'h3E};
        rom[8'hFF] = {OP_JMP, 4'd0, 6'h01};
        rom[1]     = {OP_HALT, 10'd0};
        do_reset();
        run = 1'b1;
        wait_fetch("t4_f0", 8'h00);
        wait_fetch("t4_fff", 8'hFF);
        wait_fetch("t4_f1", 8'h01);
        wait_halt("t4");
        count_idle("t4_halt_quiet", 8);
        check("t4_still_halted", 32'(halted), 32'd1);
        check("t4_pc", 32'(pmem_addr), 32'd1);

        // Run drops during WAIT: instruction completes, nothing more fetched
        clear_rom();
        rom[0] = {OP_MOVE, 4'd1, 4'd2, 2'b00};
        init_regs[2] = 16'hABCD;
        do_reset();
        run = 1'b1;
        step();
        step();
        run = 1'b0;
        step();
        step();
        check("t5_wr", 32'(rf_wr_en), 32'd1);
        check("t5_data", 32'(rf_wr_data), 32'hABCD);
        step();
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_pc", 32'(pmem_addr), 32'd1);
        count_idle("t5_quiet", 8);

        // Reset during EXEC aborts the instruction
        clear_rom();
        rom[0] = {OP_SUB, 4'd3, 4'd3, 2'b00};
        rom[1] = {OP_ADC, 4'd1, 4'd2, 2'b00};
        init_regs[3] = 16'h0042;
        init_regs[2] = 16'h0005;
        do_reset();
        run = 1'b1;
        repeat (7) step();
        check("t6_zero_flag", 32'(alu_in_flags), 32'b0100);
        check("t6_in_flight", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pc", 32'(pmem_addr), 32'd0);
        check("t6_flags", 32'(alu_in_flags), 32'd0);
        check("t6_wren", 32'(rf_wr_en), 32'd0);
        run = 1'b0;
        step();
        rst = 1'b0;
        count_idle("t6_quiet", 6);

        // Random programs: steady Run, then randomly toggled Run
        for (int it = 0; it < 3; it++) begin
            for (int a = 0; a < 256; a++) rom[a] = rand_instr();
            for (int r = 0; r < 16; r++)
                init_regs[r] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(0, 65535));
            do_reset();
            run = 1'b1;
            repeat (400) step();
            for (int c = 0; c < 400; c++) begin
                run = ($urandom_range(0, 3) != 0);
                step();
            end
            drain("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
